// File: rtl/vscale_dmem_wb_bridge_pkg.sv
// Shared constants and types for the vscale data-memory to Wishbone bridge.
package vscale_dmem_wb_bridge_pkg;

    // Width of the pipeline's memory-type field; bit 2 is the unsigned-load flag.
    localparam int unsigned MEM_TYPE_WIDTH = 3;

    // Wishbone byte-lane select width for a 32-bit data bus.
    localparam int unsigned WB_SEL_WIDTH = 4;

    // Access-size codes carried in dmem_size[1:0].
    localparam logic [1:0] MEM_TYPE_SB = 2'd0;
    localparam logic [1:0] MEM_TYPE_SH = 2'd1;
    localparam logic [1:0] MEM_TYPE_SW = 2'd2;

    localparam logic [1:0] SIZE_BYTE    = MEM_TYPE_SB;
    localparam logic [1:0] SIZE_HALF    = MEM_TYPE_SH;
    localparam logic [1:0] SIZE_WORD    = MEM_TYPE_SW;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    // Bridge FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBus   = 2'd1,
        StResp  = 2'd2,
        StFault = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/vscale_dmem_wb_bridge_if.sv
// Pipeline data-memory port plus Wishbone B4 classic master signals.
interface vscale_dmem_wb_bridge_if #(
    parameter int unsigned XPR_LEN = 32
);
    import vscale_dmem_wb_bridge_pkg::*;

    // Pipeline side
    logic                      dmem_en;
    logic                      dmem_wen;
    logic [MEM_TYPE_WIDTH-1:0] dmem_size;
    logic [XPR_LEN-1:0]        dmem_addr;
    logic [XPR_LEN-1:0]        dmem_wdata_delayed;
    logic                      dmem_wait;
    logic [XPR_LEN-1:0]        dmem_rdata;
    logic                      dmem_badmem_e;

    // Wishbone side
    logic                      wb_cyc_o;
    logic                      wb_stb_o;
    logic                      wb_we_o;
    logic [XPR_LEN-1:0]        wb_adr_o;
    logic [WB_SEL_WIDTH-1:0]   wb_sel_o;
    logic [XPR_LEN-1:0]        wb_dat_o;
    logic [XPR_LEN-1:0]        wb_dat_i;
    logic                      wb_ack_i;
    logic                      wb_err_i;

    // The bridge itself: serves the pipeline and masters the bus.
    modport master (
        input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        output dmem_wait, dmem_rdata, dmem_badmem_e,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    // The surroundings: pipeline requester and Wishbone slave.
    modport slave (
        output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        input  dmem_wait, dmem_rdata, dmem_badmem_e,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/vscale_wb_sel_gen.sv
// Byte-lane select and misalignment decode for a single data access.
module vscale_wb_sel_gen
    import vscale_dmem_wb_bridge_pkg::*;
(
    input  logic [1:0]              size,
    input  logic [1:0]              addr_lo,
    output logic [WB_SEL_WIDTH-1:0] sel,
    output logic                    misalign
);

    // Decode lanes from size and low address bits; size 3 is always a fault.
    always_comb begin
        sel      = '0;
        misalign = 1'b0;
        case (size)
            SIZE_BYTE: begin
                sel = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                sel      = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            SIZE_WORD: begin
                sel      = 4'b1111;
                misalign = |addr_lo;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vscale_dmem_wb_bridge.sv
// Wishbone B4 classic master behind the vscale pipeline's data-memory port.
// One bus cycle per request, issued the cycle after accept so the delayed
// store data is available; faults are reported as a one-cycle badmem pulse.
module vscale_dmem_wb_bridge
    import vscale_dmem_wb_bridge_pkg::*;
#(
    parameter int unsigned XPR_LEN = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    vscale_dmem_wb_bridge_if.master       bus
);

    localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(TIMEOUT);

    bridge_state_e           state_q, state_d;
    logic [TO_W-1:0]         cnt_q, cnt_d;
    logic                    wen_q;
    logic [XPR_LEN-1:0]      adr_q;
    logic [WB_SEL_WIDTH-1:0] sel_q;
    logic [XPR_LEN-1:0]      rdata_q;

    logic [WB_SEL_WIDTH-1:0] req_sel;
    logic                    req_misalign;
    logic                    accept;
    logic                    in_bus;
    logic                    bus_ok;
    logic [TO_W-1:0]         cnt_inc;

    // Unsigned-load flag only matters to the pipeline's extension logic.
    logic unused_size_msb;
    assign unused_size_msb = bus.dmem_size[2];

    vscale_wb_sel_gen u_sel_gen (
        .size     (bus.dmem_size[1:0]),
        .addr_lo  (bus.dmem_addr[1:0]),
        .sel      (req_sel),
        .misalign (req_misalign)
    );

    assign in_bus  = (state_q == StBus);
    assign accept  = bus.dmem_en && !in_bus;
    assign bus_ok  = bus.wb_ack_i && !bus.wb_err_i;
    assign cnt_inc = cnt_q + 1'b1;

    // Next state and timeout counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StBus: begin
                cnt_d = cnt_inc;
                if (bus_ok) begin
                    state_d = StResp;
                end else if (bus.wb_err_i) begin
                    state_d = StFault;
                end else if (cnt_inc == TIMEOUT_VAL) begin
                    state_d = StFault;
                end
            end
            default: begin
                if (bus.dmem_en) begin
                    state_d = req_misalign ? StFault : StBus;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State register; reset drops cyc/stb immediately via state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture request attributes on accept; latch load data on a clean ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wen_q   <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wen_q <= bus.dmem_wen;
                adr_q <= {bus.dmem_addr[XPR_LEN-1:2], 2'b00};
                sel_q <= req_sel;
            end
            if (in_bus && bus_ok && !wen_q) begin
                rdata_q <= bus.wb_dat_i;
            end
        end
    end

    // Bus and pipeline outputs, all decoded from the current state.
    always_comb begin
        bus.wb_cyc_o      = in_bus;
        bus.wb_stb_o      = in_bus;
        bus.wb_we_o       = in_bus && wen_q;
        bus.wb_adr_o      = in_bus ? adr_q : '0;
        bus.wb_sel_o      = in_bus ? sel_q : '0;
        bus.wb_dat_o      = in_bus ? bus.dmem_wdata_delayed : '0;
        bus.dmem_wait     = in_bus;
        bus.dmem_badmem_e = (state_q == StFault);
        bus.dmem_rdata    = rdata_q;
    end

endmodule

// File: tb/tb_vscale_dmem_wb_bridge.sv
// Self-checking bench: directed scenarios plus randomized transactions
// compared against a transaction-level reference model.
module tb_vscale_dmem_wb_bridge;

    localparam int unsigned TIMEOUT = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_rdata;

    vscale_dmem_wb_bridge_if #(.XPR_LEN(32)) bus_if ();

    vscale_dmem_wb_bridge #(
        .XPR_LEN (32),
        .TIMEOUT (TIMEOUT),
        .TO_W    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: an access is legal only if size is 1/2/4 bytes and naturally aligned.
    function automatic bit model_misaligned(input int size, input logic [31:0] a);
        int nbytes;
        if (size == 3) return 1'b1;
        nbytes = 1 << size;
        return (a % nbytes) != 0;
    endfunction

    // Reference: a lane is selected when its byte lies inside [addr, addr+nbytes).
    function automatic logic [3:0] model_sel(input int size, input logic [31:0] a);
        logic [3:0] s;
        int off;
        int nbytes;
        s = 4'b0000;
        off = a % 4;
        nbytes = 1 << size;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nbytes) s[i] = 1'b1;
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus_if.dmem_en = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Run one request. Starts in a cycle where the bridge can accept and ends
    // in the response cycle (RESP or FAULT), so callers may issue back-to-back.
    task automatic run_txn(input bit wen, input int size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input bit err,
                           input bit ack_too, input bit no_ack, input logic [31:0] rd);
        int  nb;
        int  exp_nb;
        bit  hit;
        bit  fault;
        check_eq("accept_wait", bus_if.dmem_wait, 32'd0);
        bus_if.dmem_en   = 1'b1;
        bus_if.dmem_wen  = wen;
        bus_if.dmem_size = {1'($urandom_range(0, 1)), 2'(size)};
        bus_if.dmem_addr = addr;
        #1;
        check_eq("accept_cyc", bus_if.wb_cyc_o, 32'd0);
        step();
        bus_if.dmem_en            = 1'b0;
        bus_if.dmem_wdata_delayed = wdata;
        bus_if.dmem_addr          = $urandom;
        #1;
        if (model_misaligned(size, addr)) begin
            check_eq("mis_cyc", bus_if.wb_cyc_o, 32'd0);
            check_eq("mis_badmem", bus_if.dmem_badmem_e, 32'd1);
            check_eq("mis_wait", bus_if.dmem_wait, 32'd0);
            check_eq("mis_rdata", bus_if.dmem_rdata, exp_rdata);
            return;
        end
        nb     = 0;
        exp_nb = no_ack ? TIMEOUT : waits + 1;
        while (bus_if.dmem_wait && nb < TIMEOUT + 4) begin
            check_eq("bus_cyc", bus_if.wb_cyc_o, 32'd1);
            check_eq("bus_stb", bus_if.wb_stb_o, 32'd1);
            check_eq("bus_we", bus_if.wb_we_o, 32'(wen));
            check_eq("bus_adr", bus_if.wb_adr_o, {addr[31:2], 2'b00});
            check_eq("bus_sel", bus_if.wb_sel_o, 32'(model_sel(size, addr)));
            check_eq("bus_dat_o", bus_if.wb_dat_o, wdata);
            check_eq("bus_badmem", bus_if.dmem_badmem_e, 32'd0);
            hit = !no_ack && (nb == waits);
            bus_if.wb_ack_i = hit && (!err || ack_too);
            bus_if.wb_err_i = hit && err;
            bus_if.wb_dat_i = hit ? rd : $urandom;
            step();
            bus_if.wb_ack_i = 1'b0;
            bus_if.wb_err_i = 1'b0;
            bus_if.wb_dat_i = $urandom;
            nb++;
        end
        check_eq("bus_cycles", 32'(nb), 32'(exp_nb));
        fault = no_ack || err;
        if (!fault && !wen) exp_rdata = rd;
        check_eq("resp_cyc", bus_if.wb_cyc_o, 32'd0);
        check_eq("resp_wait", bus_if.dmem_wait, 32'd0);
        check_eq("resp_badmem", bus_if.dmem_badmem_e, 32'(fault));
        check_eq("resp_rdata", bus_if.dmem_rdata, exp_rdata);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_rdata = 32'h0;
        reset     = 1'b0;
        bus_if.dmem_en            = 1'b0;
        bus_if.dmem_wen           = 1'b0;
        bus_if.dmem_size          = '0;
        bus_if.dmem_addr          = '0;
        bus_if.dmem_wdata_delayed = '0;
        bus_if.wb_dat_i           = '0;
        bus_if.wb_ack_i           = 1'b0;
        bus_if.wb_err_i           = 1'b0;

        // Reset state
        #12;
        check_eq("rst_cyc", bus_if.wb_cyc_o, 32'd0);
        check_eq("rst_stb", bus_if.wb_stb_o, 32'd0);
        check_eq("rst_we", bus_if.wb_we_o, 32'd0);
        check_eq("rst_adr", bus_if.wb_adr_o, 32'd0);
        check_eq("rst_sel", bus_if.wb_sel_o, 32'd0);
        check_eq("rst_dat_o", bus_if.wb_dat_o, 32'd0);
        check_eq("rst_wait", bus_if.dmem_wait, 32'd0);
        check_eq("rst_badmem", bus_if.dmem_badmem_e, 32'd0);
        check_eq("rst_rdata", bus_if.dmem_rdata, 32'd0);
        #10;
        reset = 1'b1;
        step();

        // LW, two wait states
        run_txn(1'b0, 2, 32'h0000_1008, 32'h1111_2222, 2, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        idle(1);
        check_eq("idle_badmem", bus_if.dmem_badmem_e, 32'd0);
        // SB, immediate ack
        run_txn(1'b1, 0, 32'h0000_2003, 32'h5A5A_5A5A, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
        // Misaligned LH
        run_txn(1'b0, 1, 32'h0000_1001, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
        check_eq("mis_pulse_end", bus_if.dmem_badmem_e, 32'd0);
        // Timeout, then a normal request
        run_txn(1'b0, 2, 32'h0000_3000, 32'h0, 0, 1'b0, 1'b0, 1'b1, 32'h0);
        run_txn(1'b0, 2, 32'h0000_3004, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001);
        idle(1);
        // Back-to-back LW then SW, second accepted in the RESP cycle
        run_txn(1'b0, 2, 32'h0000_0010, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D);
        run_txn(1'b1, 2, 32'h0000_0014, 32'h7654_3210, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
        // Error together with ack: fault, rdata unchanged
        run_txn(1'b0, 2, 32'h0000_0020, 32'h0, 1, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
        idle(1);

        // Reset mid-BUS
        bus_if.dmem_en   = 1'b1;
        bus_if.dmem_wen  = 1'b0;
        bus_if.dmem_size = 3'd2;
        bus_if.dmem_addr = 32'h0000_0040;
        step();
        bus_if.dmem_en = 1'b0;
        check_eq("pre_rst_cyc", bus_if.wb_cyc_o, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_cyc", bus_if.wb_cyc_o, 32'd0);
        check_eq("mid_rst_stb", bus_if.wb_stb_o, 32'd0);
        check_eq("mid_rst_wait", bus_if.dmem_wait, 32'd0);
        exp_rdata = 32'h0;
        #2;
        reset = 1'b1;
        bus_if.wb_ack_i = 1'b1;
        bus_if.wb_dat_i = 32'hBADB_AD00;
        step();
        bus_if.wb_ack_i = 1'b0;
        check_eq("stray_ack_cyc", bus_if.wb_cyc_o, 32'd0);
        check_eq("stray_ack_wait", bus_if.dmem_wait, 32'd0);
        check_eq("stray_ack_badmem", bus_if.dmem_badmem_e, 32'd0);
        check_eq("stray_ack_rdata", bus_if.dmem_rdata, 32'd0);
        run_txn(1'b0, 2, 32'h0000_0044, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h4444_4444);
        idle(1);

        // Randomized transactions
        for (int t = 0; t < 80; t++) begin
            bit          wen;
            int          size;
            logic [31:0] addr;
            int          waits;
            bit          err;
            bit          ack_too;
            bit          no_ack;
            wen     = 1'($urandom_range(0, 1));
            size    = $urandom_range(0, 3);
            addr    = $urandom;
            if ($urandom_range(0, 2) != 0 && size != 3) addr = addr & ~((32'd1 << size) - 1);
            waits   = $urandom_range(0, TIMEOUT - 1);
            err     = ($urandom_range(0, 5) == 0);
            ack_too = 1'($urandom_range(0, 1));
            no_ack  = !err && ($urandom_range(0, 9) == 0);
            run_txn(wen, size, addr, $urandom, waits, err, ack_too, no_ack, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
